// File: rtl/sccb_slave.sv
// -----------------------------------------------------------------------------
// sccb_slave
//   SCCB / I2C-style target that stands in for the OV5642 register port
//   (8-bit device ID, 16-bit register address, 8-bit data). It is intended for
//   loopback bring-up and simulation of the SCCB master. It decodes the
//   SIOC/SIOD pin traffic and turns it into strobes on a simple register-file
//   interface.
//
// Ports
//   i_clk        system clock, at least 16x the SIOC frequency
//   i_rst        synchronous, active-high reset
//   i_sioc       SCCB clock from the master (asynchronous)
//   i_siod_in    SCCB data as seen on the pin (asynchronous)
//   o_siod_oe    1 = pull SIOD low (open drain), 0 = release
//   o_reg_addr   current register address
//   o_reg_wdata  write data, valid while o_reg_we is high
//   o_reg_we     one-cycle write strobe
//   o_reg_re     one-cycle read strobe
//   i_reg_rdata  read data, valid on the cycle after o_reg_re
//   o_busy       high whenever the FSM is not idle
//   o_start_det  one-cycle pulse on each START / repeated START
//   o_stop_det   one-cycle pulse on each STOP
// -----------------------------------------------------------------------------
module sccb_slave #(
    parameter logic [7:0] DEVICE_ID = 8'h78
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sioc,
    input  logic        i_siod_in,
    output logic        o_siod_oe,
    output logic [15:0] o_reg_addr,
    output logic [7:0]  o_reg_wdata,
    output logic        o_reg_we,
    output logic        o_reg_re,
    input  logic [7:0]  i_reg_rdata,
    output logic        o_busy,
    output logic        o_start_det,
    output logic        o_stop_det
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID,
        S_ADDR_HI,
        S_ADDR_LO,
        S_WDATA,
        S_ACK,
        S_RDATA,
        S_MACK,
        S_WAIT_STOP
    } state_t;

    // Synchronizers plus one history stage for edge detection. They reset to
    // the idle-bus level so that leaving reset never looks like a bus event.
    logic r_sioc_s1, r_sioc_s2, r_sioc_d;
    logic r_siod_s1, r_siod_s2, r_siod_d;

    state_t      r_state;
    state_t      r_next;       // receive state to enter once the ACK completes
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_rx_shift;   // the 8th bit is taken straight from the pin
    logic [7:0]  r_tx_shift;
    logic        r_ack_on;     // ACK low phase already started
    logic        r_rd_armed;   // next drive edge in RDATA sends the MSB
    logic        r_re_pend;    // read strobe one cycle after an address bump
    logic        r_cap;        // read data is valid this cycle
    logic        r_inc;        // post-write address increment
    logic        r_siod_oe;
    logic [15:0] r_reg_addr;
    logic [7:0]  r_reg_wdata;
    logic        r_reg_we;
    logic        r_reg_re;
    logic        r_start_det;
    logic        r_stop_det;

    logic       w_start;
    logic       w_stop;
    logic       w_rise;
    logic       w_fall;
    logic [7:0] w_rx_byte;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sioc_s1 <= 1'b1;
            r_sioc_s2 <= 1'b1;
            r_sioc_d  <= 1'b1;
            r_siod_s1 <= 1'b1;
            r_siod_s2 <= 1'b1;
            r_siod_d  <= 1'b1;
        end else begin
            r_sioc_s1 <= i_sioc;
            r_sioc_s2 <= r_sioc_s1;
            r_sioc_d  <= r_sioc_s2;
            r_siod_s1 <= i_siod_in;
            r_siod_s2 <= r_siod_s1;
            r_siod_d  <= r_siod_s2;
        end
    end

    // SIOC must be stable high across the SIOD transition for START/STOP.
    assign w_start   = r_sioc_s2 & r_sioc_d & r_siod_d & ~r_siod_s2;
    assign w_stop    = r_sioc_s2 & r_sioc_d & ~r_siod_d & r_siod_s2;
    assign w_rise    = r_sioc_s2 & ~r_sioc_d;
    assign w_fall    = ~r_sioc_s2 & r_sioc_d;
    assign w_rx_byte = {r_rx_shift, r_siod_s2};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_next      <= S_IDLE;
            r_bit_cnt   <= 3'd7;
            r_rx_shift  <= 7'd0;
            r_tx_shift  <= 8'd0;
            r_ack_on    <= 1'b0;
            r_rd_armed  <= 1'b0;
            r_re_pend   <= 1'b0;
            r_cap       <= 1'b0;
            r_inc       <= 1'b0;
            r_siod_oe   <= 1'b0;
            r_reg_addr  <= 16'd0;
            r_reg_wdata <= 8'd0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
        end else begin
            r_reg_we    <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
            r_reg_re    <= r_re_pend;
            r_re_pend   <= 1'b0;
            r_inc       <= 1'b0;
            // Read data arrives the cycle after the strobe.
            r_cap       <= r_reg_re;
            if (r_cap)
                r_tx_shift <= i_reg_rdata;
            if (r_inc)
                r_reg_addr <= r_reg_addr + 16'd1;

            if (w_start) begin
                r_start_det <= 1'b1;
                r_siod_oe   <= 1'b0;
                r_bit_cnt   <= 3'd7;
                r_ack_on    <= 1'b0;
                r_rd_armed  <= 1'b0;
                r_state     <= S_ID;
            end else if (w_stop) begin
                r_stop_det  <= 1'b1;
                r_siod_oe   <= 1'b0;
                r_bit_cnt   <= 3'd7;
                r_ack_on    <= 1'b0;
                r_rd_armed  <= 1'b0;
                r_state     <= S_IDLE;
            end else begin
                case (r_state)
                    S_ID, S_ADDR_HI, S_ADDR_LO, S_WDATA: begin
                        if (w_rise) begin
                            r_rx_shift <= w_rx_byte[6:0];
                            if (r_bit_cnt != 3'd0) begin
                                r_bit_cnt <= r_bit_cnt - 3'd1;
                            end else begin
                                r_bit_cnt <= 3'd7;
                                r_ack_on  <= 1'b0;
                                r_state   <= S_ACK;
                                case (r_state)
                                    S_ID: begin
                                        if (w_rx_byte[7:1] != DEVICE_ID[7:1]) begin
                                            r_state <= S_WAIT_STOP;
                                        end else if (w_rx_byte[0]) begin
                                            // Read uses whatever address is retained.
                                            r_reg_re <= 1'b1;
                                            r_next   <= S_RDATA;
                                        end else begin
                                            r_next <= S_ADDR_HI;
                                        end
                                    end
                                    S_ADDR_HI: begin
                                        r_reg_addr[15:8] <= w_rx_byte;
                                        r_next           <= S_ADDR_LO;
                                    end
                                    S_ADDR_LO: begin
                                        r_reg_addr[7:0] <= w_rx_byte;
                                        r_next          <= S_WDATA;
                                    end
                                    default: begin
                                        // Address is held during the strobe and
                                        // bumped on the following cycle.
                                        r_reg_wdata <= w_rx_byte;
                                        r_reg_we    <= 1'b1;
                                        r_inc       <= 1'b1;
                                        r_next      <= S_WDATA;
                                    end
                                endcase
                            end
                        end
                    end

                    S_ACK: begin
                        if (w_fall) begin
                            if (!r_ack_on) begin
                                r_siod_oe <= 1'b1;
                                r_ack_on  <= 1'b1;
                            end else begin
                                r_ack_on <= 1'b0;
                                if (r_next == S_RDATA) begin
                                    // The edge that ends the ACK also launches the MSB.
                                    r_siod_oe  <= ~r_tx_shift[7];
                                    r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                                    r_bit_cnt  <= 3'd7;
                                    r_state    <= S_RDATA;
                                end else begin
                                    r_siod_oe <= 1'b0;
                                    r_state   <= r_next;
                                end
                            end
                        end
                    end

                    S_RDATA: begin
                        if (w_fall) begin
                            if (r_rd_armed) begin
                                r_rd_armed <= 1'b0;
                                r_siod_oe  <= ~r_tx_shift[7];
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                                r_bit_cnt  <= 3'd7;
                            end else if (r_bit_cnt == 3'd0) begin
                                r_siod_oe <= 1'b0;
                                r_state   <= S_MACK;
                            end else begin
                                r_siod_oe  <= ~r_tx_shift[7];
                                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                                r_bit_cnt  <= r_bit_cnt - 3'd1;
                            end
                        end
                    end

                    S_MACK: begin
                        if (w_rise) begin
                            if (!r_siod_s2) begin
                                // Strobe one cycle later so it sees the new address.
                                r_reg_addr <= r_reg_addr + 16'd1;
                                r_re_pend  <= 1'b1;
                                r_rd_armed <= 1'b1;
                                r_state    <= S_RDATA;
                            end else begin
                                r_state <= S_WAIT_STOP;
                            end
                        end
                    end

                    S_WAIT_STOP: begin
                        r_siod_oe <= 1'b0;
                    end

                    S_IDLE: begin
                        r_siod_oe <= 1'b0;
                    end

                    default: begin
                        r_siod_oe <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_siod_oe   = r_siod_oe;
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_reg_wdata;
    assign o_reg_we    = r_reg_we;
    assign o_reg_re    = r_reg_re;
    assign o_busy      = (r_state != S_IDLE);
    assign o_start_det = r_start_det;
    assign o_stop_det  = r_stop_det;

endmodule

// File: tb/tb_sccb_slave.sv
// -----------------------------------------------------------------------------
// tb_sccb_slave
//   Bit-banged SCCB master driving sccb_slave over an open-drain SIOD line,
//   with a register-file stand-in on the register port and a transaction-level
//   reference model (address pointer + memory image) for expected results.
// -----------------------------------------------------------------------------
module tb_sccb_slave;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        w_line;
    logic        o_siod_oe;
    logic [15:0] o_reg_addr;
    logic [7:0]  o_reg_wdata;
    logic        o_reg_we;
    logic        o_reg_re;
    logic [7:0]  i_reg_rdata;
    logic        o_busy;
    logic        o_start_det;
    logic        o_stop_det;

    always #5 i_clk = ~i_clk;

    // Open-drain bus with pull-up.
    assign w_line = m_sda & ~o_siod_oe;

    sccb_slave #(.DEVICE_ID(8'h78)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sioc      (m_scl),
        .i_siod_in   (w_line),
        .o_siod_oe   (o_siod_oe),
        .o_reg_addr  (o_reg_addr),
        .o_reg_wdata (o_reg_wdata),
        .o_reg_we    (o_reg_we),
        .o_reg_re    (o_reg_re),
        .i_reg_rdata (i_reg_rdata),
        .o_busy      (o_busy),
        .o_start_det (o_start_det),
        .o_stop_det  (o_stop_det)
    );

    function automatic logic [7:0] init_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // Register-file stand-in and bus monitors.
    logic [7:0]  env_mem [65536];
    bit          written [65536];
    logic [23:0] we_q[$];
    logic [15:0] re_q[$];
    int          n_start = 0;
    int          n_stop  = 0;
    int          n_oe    = 0;

    always @(posedge i_clk) begin
        if (o_reg_we) begin
            we_q.push_back({o_reg_addr, o_reg_wdata});
            env_mem[o_reg_addr] <= o_reg_wdata;
            written[o_reg_addr] <= 1'b1;
        end
        if (o_reg_re) begin
            re_q.push_back(o_reg_addr);
            i_reg_rdata <= written[o_reg_addr] ? env_mem[o_reg_addr] : init_byte(o_reg_addr);
        end
        if (o_start_det) n_start <= n_start + 1;
        if (o_stop_det)  n_stop  <= n_stop + 1;
        if (o_siod_oe)   n_oe    <= n_oe + 1;
    end

    // Reference model state.
    logic [7:0]  ref_mem [65536];
    logic [15:0] mdl_addr = 16'd0;
    logic [7:0]  wbuf [8];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic m_bit(input logic b, output logic s);
        m_sda = b;  wait_clk(8);
        m_scl = 1;  wait_clk(8);
        s = w_line; wait_clk(8);
        m_scl = 0;  wait_clk(8);
    endtask

    task automatic m_start;
        m_sda = 1; wait_clk(8);
        m_scl = 1; wait_clk(8);
        m_sda = 0; wait_clk(8);
        m_scl = 0; wait_clk(8);
    endtask

    task automatic m_stop;
        m_sda = 0; wait_clk(8);
        m_scl = 1; wait_clk(8);
        m_sda = 1; wait_clk(8);
    endtask

    task automatic m_wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(b[i], s);
        m_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic m_rbyte(input logic nack, output logic [7:0] d);
        logic s;
        d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            m_bit(1'b1, s);
            d = {d[6:0], s};
        end
        m_bit(nack, s);
    endtask

    // Write transaction: ID 0x78, address a, n data bytes from wbuf.
    task automatic wr_txn(input logic [15:0] a, input int n);
        logic ack;
        logic [15:0] wa;
        m_start;
        m_wbyte(8'h78, ack);   chk("wr_id_ack", ack, 1);
        m_wbyte(a[15:8], ack); chk("wr_ahi_ack", ack, 1);
        m_wbyte(a[7:0], ack);  chk("wr_alo_ack", ack, 1);
        for (int k = 0; k < n; k++) begin
            m_wbyte(wbuf[k], ack);
            chk("wr_data_ack", ack, 1);
        end
        m_stop;
        wait_clk(4);
        chk("wr_count", we_q.size(), n);
        for (int k = 0; k < n; k++) begin
            wa = a + 16'(k);
            ref_mem[wa] = wbuf[k];
            if (we_q.size() > 0) chk("wr_item", we_q.pop_front(), {wa, wbuf[k]});
        end
        we_q.delete();
        mdl_addr = a + 16'(n);
        chk("wr_addr_after", o_reg_addr, mdl_addr);
        chk("wr_busy_after", o_busy, 0);
    endtask

    // Read transaction: ID 0x79, n bytes, master NACKs the last one.
    task automatic rd_txn(input int n);
        logic ack;
        logic [7:0] d;
        logic [15:0] ra;
        m_start;
        m_wbyte(8'h79, ack); chk("rd_id_ack", ack, 1);
        for (int k = 0; k < n; k++) begin
            ra = mdl_addr + 16'(k);
            m_rbyte(k == n - 1, d);
            chk("rd_data", d, ref_mem[ra]);
        end
        m_stop;
        wait_clk(4);
        chk("rd_count", re_q.size(), n);
        for (int k = 0; k < n; k++) begin
            ra = mdl_addr + 16'(k);
            if (re_q.size() > 0) chk("rd_addr", re_q.pop_front(), ra);
        end
        re_q.delete();
        mdl_addr = mdl_addr + 16'(n - 1);
        chk("rd_addr_after", o_reg_addr, mdl_addr);
        chk("rd_busy_after", o_busy, 0);
    endtask

    initial begin
        logic ack;
        logic s;
        int s0, p0, o0, n;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(16'(i));

        wait_clk(5);
        i_rst = 0;
        wait_clk(2);
        chk("rst_oe", o_siod_oe, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_addr", o_reg_addr, 16'h0000);
        chk("rst_we_re", {o_reg_we, o_reg_re, o_start_det, o_stop_det}, 4'b0);
        chk("rst_wdata", o_reg_wdata, 8'h00);

        // Single-byte write.
        wbuf[0] = 8'h82;
        wr_txn(16'h3008, 1);
        chk("wr_addr_3009", o_reg_addr, 16'h3009);

        // Read back 0x56 from 0x300A after an address-only write phase.
        wbuf[0] = 8'h56;
        wr_txn(16'h300A, 1);
        wr_txn(16'h300A, 0);
        rd_txn(1);

        // ID mismatch.
        s0 = n_start; p0 = n_stop; o0 = n_oe;
        m_start;
        m_wbyte(8'h42, ack); chk("bad_id_ack", ack, 0);
        m_wbyte(8'h30, ack); chk("bad_id_byte2_ack", ack, 0);
        chk("bad_id_busy", o_busy, 1);
        m_stop;
        wait_clk(4);
        chk("bad_id_oe_cycles", n_oe - o0, 0);
        chk("bad_id_we", we_q.size(), 0);
        chk("bad_id_re", re_q.size(), 0);
        chk("bad_id_starts", n_start - s0, 1);
        chk("bad_id_stops", n_stop - p0, 1);
        chk("bad_id_idle", o_busy, 0);

        // Address wrap across a two-byte write.
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        wr_txn(16'hFFFF, 2);

        // STOP after four WDATA bits discards the partial byte.
        m_start;
        m_wbyte(8'h78, ack); chk("abort_id_ack", ack, 1);
        m_wbyte(8'h12, ack); chk("abort_ahi_ack", ack, 1);
        m_wbyte(8'h34, ack); chk("abort_alo_ack", ack, 1);
        for (int i = 0; i < 4; i++) m_bit(1'b1, s);
        m_stop;
        wait_clk(4);
        chk("abort_we", we_q.size(), 0);
        chk("abort_idle", o_busy, 0);
        chk("abort_addr", o_reg_addr, 16'h1234);
        mdl_addr = 16'h1234;

        // Repeated START in the middle of ADDR_LO restarts at the ID byte.
        s0 = n_start;
        m_start;
        m_wbyte(8'h78, ack);
        m_wbyte(8'h56, ack);
        for (int i = 0; i < 3; i++) m_bit(1'b0, s);
        wbuf[0] = 8'h99;
        wr_txn(16'hABCD, 1);
        chk("restart_starts", n_start - s0, 2);

        // Multi-byte read across the register file.
        rd_txn(3);

        // Reset while the slave is pulling SIOD low during RDATA.
        wbuf[0] = 8'h00;
        wr_txn(16'h4000, 1);
        wr_txn(16'h4000, 0);
        m_start;
        m_wbyte(8'h79, ack); chk("rstrd_id_ack", ack, 1);
        m_sda = 1; wait_clk(8);
        m_scl = 1; wait_clk(8);
        chk("rstrd_pre_oe", o_siod_oe, 1);
        i_rst = 1;
        wait_clk(1);
        chk("rstrd_oe", o_siod_oe, 0);
        chk("rstrd_busy", o_busy, 0);
        chk("rstrd_addr", o_reg_addr, 16'h0000);
        i_rst = 0;
        m_scl = 0; wait_clk(8);
        m_stop;
        wait_clk(4);
        re_q.delete();
        mdl_addr = 16'h0000;

        // Randomized mix of writes and reads against the reference model.
        for (int t = 0; t < 16; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                wr_txn(16'($urandom), n);
            end else begin
                rd_txn($urandom_range(1, 3));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sccb_slave.md
Name: sccb_slave

Overview:
- SCCB/I2C-style responder: the target end of the SCCB master link.
- Models the OV5642 register port: 8-bit device ID, 16-bit register address, 8-bit data.
- Used as a synthesizable camera-register stand-in for loopback bring-up and simulation of the sccb_top master.
- Sits between the SIOC/SIOD pins (or the master's pin outputs) and a simple external register-file interface.

Parameters:
- DEVICE_ID, 8'h78, 8-bit write ID. Bit 0 is ignored in the compare; R/W is taken from received bit 0. Read ID is 8'h79.

Ports:
- i_clk  in  1  system clock; must be ≥16× SIOC frequency (100 MHz nominal).
- i_rst  in  1  synchronous, active-high reset.
- i_sioc  in  1  SCCB clock from master; asynchronous.
- i_siod_in  in  1  SCCB data as seen on the pin; asynchronous.
- o_siod_oe  out  1  1 = pull SIOD low (open-drain); 0 = release.
- o_reg_addr  out  16  current register address.
- o_reg_wdata  out  8  write data; valid while o_reg_we = 1.
- o_reg_we  out  1  one-cycle write strobe.
- o_reg_re  out  1  one-cycle read strobe.
- i_reg_rdata  in  8  read data; must be valid on the cycle after o_reg_re.
- o_busy  out  1  high whenever state is not IDLE.
- o_start_det  out  1  one-cycle pulse on each START or repeated START.
- o_stop_det  out  1  one-cycle pulse on each STOP.

Behaviour:
- Input sync: 2-FF synchronizer on i_sioc and i_siod_in, plus one history register for edge detection. Pin-to-event latency is 3 i_clk cycles.
- Events, all on synced signals:
  - START = SIOD falls while SIOC = 1.
  - STOP = SIOD rises while SIOC = 1.
  - Sample edge = SIOC rising edge.
  - Drive edge = SIOC falling edge.
- Reset: state = IDLE; o_siod_oe = 0; o_reg_addr = 0; o_reg_wdata = 0; o_reg_we = 0; o_reg_re = 0; o_busy = 0; o_start_det = 0; o_stop_det = 0; bit counter = 7; shift registers = 0.
- States: IDLE, ID, ADDR_HI, ADDR_LO, WDATA, ACK (slave drives ACK), RDATA, MACK (master ACK/NACK), WAIT_STOP.
- Receive states (ID, ADDR_HI, ADDR_LO, WDATA):
  - Shift SIOD in MSB first on each sample edge.
  - After the 8th sample, move to ACK, remembering the next receive state.
- ACK state:
  - o_siod_oe rises on the first drive edge after the 8th bit.
  - o_siod_oe falls on the next drive edge; then the state advances.
- ID byte:
  - On mismatch of bits [7:1] against DEVICE_ID[7:1]: no ACK, go to WAIT_STOP.
  - On match with bit0 = 0: ACK, then ADDR_HI.
  - On match with bit0 = 1: o_reg_re pulses on the cycle of the 8th sample. i_reg_rdata is captured into the tx shift register 1 cycle later. ACK, then RDATA.
- ADDR_HI: loads o_reg_addr[15:8]. ADDR_LO: loads o_reg_addr[7:0]. Both load on the 8th sample.
- WDATA:
  - On the 8th sample: o_reg_wdata = byte and o_reg_we = 1 for one cycle, with o_reg_addr unchanged that cycle.
  - Address increments the next cycle, 16-bit wrap: FFFF → 0000.
  - ACK, then WDATA again for multi-byte writes.
- RDATA:
  - On each drive edge (including the one that ends ACK), o_siod_oe = ~tx_bit, MSB first.
  - After the 8th bit's drive period ends (next drive edge), o_siod_oe = 0 and state = MACK.
- MACK:
  - Sample SIOD on the sample edge.
  - If 0 (ACK): increment address, pulse o_reg_re, capture i_reg_rdata, return to RDATA.
  - If 1 (NACK): go to WAIT_STOP.
- WAIT_STOP: o_siod_oe = 0; ignore bits; exit only on START or STOP.
- START in any state, including mid-byte or in IDLE:
  - o_start_det pulse; o_siod_oe = 0; bit counter = 7; state = ID.
- STOP in any state:
  - o_stop_det pulse; o_siod_oe = 0; state = IDLE.
  - A partial byte is discarded: no o_reg_we.
- A read issued without a preceding address phase uses the retained o_reg_addr.
- START/STOP take priority over a sample edge in the same cycle.
- Reset mid-transfer: all outputs return to reset values the next cycle. Bus is released.

Test Plan:
- Write: START, 0x78, 0x30, 0x08, 0x82, STOP → o_siod_oe = 1 during each of the 4 ACK clock-high phases; single o_reg_we with addr 0x3008, wdata 0x82; o_reg_addr = 0x3009 afterwards; o_busy = 0 after STOP.
- Read: write phase 0x78 0x30 0x0A + STOP; then START, 0x79 with i_reg_rdata = 0x56 → o_reg_re with addr 0x300A; SIOD bits on 8 SIOC-high phases are 0,1,0,1,0,1,1,0; master NACK → WAIT_STOP, then IDLE on STOP. Exercise against the sccb_top master at SIOC_FREQ = 100000.
- ID mismatch: START, 0x42, 0x30 … STOP → o_siod_oe never 1; no o_reg_we or o_reg_re; o_start_det and o_stop_det each pulse once.
- Wrap: addr 0xFFFF, data 0x11, 0x22 → o_reg_we at 0xFFFF/0x11, then at 0x0000/0x22.
- Abort: STOP after 4 WDATA bits → no o_reg_we, state IDLE. Repeated START mid-ADDR_LO → state ID, bit counter 7.
- Reset: assert i_rst during RDATA while o_siod_oe = 1 → o_siod_oe = 0 and o_busy = 0 on the next cycle; o_reg_addr = 0.
